// File: rtl/booth8_pp_gen.sv
// Radix-8 Booth front end: latches X/Y, builds 3X, recodes Y into digits
// and streams one signed partial product per cycle with start/done control.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   go           start request, honoured only in IDLE
//   multiplicand signed X, captured on the go cycle
//   multiplier   signed Y, captured on the go cycle
//   busy         high in every state except IDLE
//   start        one-cycle clear strobe to the adder network
//   done         one-cycle product-valid strobe to the adder network
//   pp           signed partial product d*X (k+3 bits), zero outside ACC
module booth8_pp_gen #(
    parameter int k = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [k-1:0] multiplicand,
    input  logic [k-1:0] multiplier,
    output logic         busy,
    output logic         start,
    output logic         done,
    output logic [k+2:0] pp
);

    localparam int N  = (k + 2) / 3;
    localparam int YE = 3 * N;
    localparam int YW = YE + 1;
    localparam int KE = k + 3;
    localparam int K2 = k + 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_ACC,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [k-1:0]  r_x;
    logic signed [k+1:0]  r_x3;
    logic        [YW-1:0] r_ysr;
    logic        [CW-1:0] r_cnt;

    logic signed [YE-1:0] w_ysext;
    logic signed [k+1:0]  w_x3;
    logic                 w_last;
    logic                 w_pp_en;

    logic        [3:0]    w_grp;
    logic                 w_neg;
    logic        [2:0]    w_g;
    logic        [2:0]    w_mag;
    logic signed [k+2:0]  w_x1;
    logic signed [k+2:0]  w_x2;
    logic signed [k+2:0]  w_x3e;
    logic signed [k+2:0]  w_x4;
    logic signed [k+2:0]  w_sel;
    logic signed [k+2:0]  w_pp;

    // Sign-extend Y to the full digit span so the top digit is correct
    // for negative multipliers without a correction cycle.
    assign w_ysext = YE'($signed(multiplier));
    assign w_x3    = K2'(r_x) + (K2'(r_x) <<< 1);
    assign w_last  = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        busy    = 1'b1;
        start   = 1'b0;
        done    = 1'b0;
        w_pp_en = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (go) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                start  = 1'b1;
                w_next = S_ACC;
            end
            S_ACC: begin
                w_pp_en = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_x   <= '0;
            r_x3  <= '0;
            r_ysr <= '0;
            r_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_x   <= multiplicand;
                        r_ysr <= {w_ysext, 1'b0};
                    end
                end
                S_START: begin
                    r_x3  <= w_x3;
                    r_cnt <= '0;
                end
                S_ACC: begin
                    r_ysr <= YW'($signed(r_ysr) >>> 3);
                    r_cnt <= r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Digit recode: for a negative group the magnitude is the weighted
    // sum of the inverted low bits (4 - 2*b2 - b1 - b0).
    assign w_grp = r_ysr[3:0];
    assign w_neg = w_grp[3];
    assign w_g   = w_neg ? ~w_grp[2:0] : w_grp[2:0];
    assign w_mag = 3'({w_g[2], w_g[1]}) + 3'(w_g[0]);

    assign w_x1  = KE'(r_x);
    assign w_x2  = w_x1 <<< 1;
    assign w_x4  = w_x1 <<< 2;
    assign w_x3e = KE'(r_x3);

    always_comb begin
        w_sel = '0;
        unique case (1'b1)
            (w_mag == 3'd1): w_sel = w_x1;
            (w_mag == 3'd2): w_sel = w_x2;
            (w_mag == 3'd3): w_sel = w_x3e;
            (w_mag == 3'd4): w_sel = w_x4;
            default:         w_sel = '0;
        endcase
    end

    // k+3 bits hold +2^(k+1), so -4 * (most negative X) negates cleanly.
    assign w_pp = w_neg ? -w_sel : w_sel;
    assign pp   = w_pp_en ? w_pp : '0;

endmodule

// File: tb/tb_booth8_pp_gen.sv
// Scoreboard bench for booth8_pp_gen: directed and random operations,
// reference digits and products computed from plain arithmetic.
module tb_booth8_pp_gen;

    localparam int K = 4;
    localparam int N = (K + 2) / 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         go;
    logic [K-1:0] multiplicand;
    logic [K-1:0] multiplier;
    logic         busy;
    logic         start;
    logic         done;
    logic [K+2:0] pp;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int q_pp[$];
    int q_prod[$];
    int q_start[$];
    int q_done[$];

    booth8_pp_gen #(.k(K)) dut (
        .clk(clk),
        .rst(rst),
        .go(go),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .busy(busy),
        .start(start),
        .done(done),
        .pp(pp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: DUT output with nothing expected (cycle %0d)",
                 nm, cyc);
    endtask

    function automatic int ybit(input int y, input int j);
        if (j < 0) return 0;
        return (y >>> j) & 1;
    endfunction

    // Reference: digit i = -4*y[3i+2] + 2*y[3i+1] + y[3i] + y[3i-1]
    task automatic push_ref(input int x, input int y, input int c);
        int d;
        q_start.push_back(c + 1);
        q_done.push_back(c + N + 2);
        for (int i = 0; i < N; i++) begin
            d = -4 * ybit(y, 3*i+2) + 2 * ybit(y, 3*i+1)
                + ybit(y, 3*i) + ybit(y, 3*i-1);
            q_pp.push_back(d * x);
        end
        q_prod.push_back(x * y);
    endtask

    // Monitor: pops expectations whenever the DUT presents something.
    longint acc = 0;
    int     idx = 0;
    logic   prev_done = 1'b0;

    always @(negedge clk) begin
        int v;
        v = int'($signed(pp));
        chk("start_done_overlap", longint'(start & done), 0);
        if (prev_done) chk("busy_gap", longint'(busy), 0);
        prev_done = done;
        if (!busy) chk("idle_outputs", longint'({start, done, pp}), 0);
        if (start) begin
            if (q_start.size() == 0) unexpected("start");
            else chk("start_cycle", cyc, q_start.pop_front());
            acc = 0;
            idx = 0;
        end else if (busy && !done) begin
            if (q_pp.size() == 0) unexpected("pp");
            else chk("pp", v, q_pp.pop_front());
            acc += longint'(v) * longint'(8 ** idx);
            idx++;
        end
        if (done) begin
            if (q_done.size() == 0) begin
                unexpected("done");
            end else begin
                chk("done_cycle", cyc, q_done.pop_front());
                chk("product", acc, q_prod.pop_front());
            end
        end
    end

    task automatic rand_ops();
        multiplicand = K'($urandom);
        multiplier   = K'($urandom);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) unexpected("idle_timeout");
    endtask

    // mode 0: single go pulse; 1: go held through DONE;
    // 2: single pulse plus a go pulse in the DONE cycle.
    task automatic do_op(input int x, input int y, input int mode);
        int c;
        wait_idle();
        c = cyc;
        go = 1'b1;
        multiplicand = x[K-1:0];
        multiplier   = y[K-1:0];
        push_ref(x, y, c);
        @(posedge clk);
        #1;
        if (mode == 1) begin
            while (cyc < c + N + 2) begin
                rand_ops();
                @(posedge clk);
                #1;
            end
            @(posedge clk);
            #1;
            go = 1'b0;
        end else begin
            go = 1'b0;
            rand_ops();
            if (mode == 2) begin
                while (cyc < c + N + 2) begin
                    @(posedge clk);
                    #1;
                end
                go = 1'b1;
                @(posedge clk);
                #1;
                go = 1'b0;
            end
        end
        rand_ops();
    endtask

    task automatic chk_idle(input string nm);
        @(negedge clk);
        chk(nm, longint'({busy, start, done, pp}), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int x;
        int y;
        int t;
        rst = 1'b0;
        go  = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk_idle("reset_state");

        do_op(5, 3, 0);
        do_op(-8, -8, 0);
        do_op(7, 4, 0);
        do_op(-8, 7, 0);
        do_op(2, -5, 1);
        do_op(-3, 6, 2);

        do_op(6, 5, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        q_pp.delete();
        q_prod.delete();
        q_start.delete();
        q_done.delete();
        chk_idle("reset_in_acc");
        do_op(3, -3, 0);

        repeat (40) begin
            x = int'($urandom_range(0, 15)) - 8;
            y = int'($urandom_range(0, 15)) - 8;
            do_op(x, y, int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        t = 0;
        while (q_prod.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (q_prod.size() != 0) unexpected("drain_timeout");
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
